sdiv_stream_ctrl: RTL and testbench
===================================

Name: sdiv_stream_ctrl

Overview:
Stream front/back-end wrapped around the pipelined signed divider `fixed_sdiv`, which has a fixed latency and no stall input.
- Accepts numerator/denominator pairs on a valid/ready input stream and drives the divider operands.
- Tracks each in-flight operation with a tag delay line and captures quotients into a result FIFO.
- Presents results in order on a valid/ready output stream.
- Uses credit-based issue, so no divider result is ever dropped under output backpressure.
- Resolves divide-by-zero and INT_MIN/-1 overflow itself, with saturated results and flags.

Parameters:
- DW, 32, operand/quotient width (signed two's complement)
- DIV_LAT, 4, divider latency in cycles from operand change to matching quotient (≥1)
- FIFO_DEPTH, 8, result FIFO entries; must be ≥ DIV_LAT+2, power of two

Ports:
- sys_clk  in  1  single clock for the block and the divider
- sys_rst  in  1  synchronous, active-high reset; top drives the divider's sys_rst_n with ~sys_rst
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept a pair
- in_numer  in  DW  signed numerator
- in_denom  in  DW  signed denominator
- div_numer  out  DW  registered divider numerator
- div_denom  out  DW  registered divider denominator
- div_quotient  in  DW  divider result, valid DIV_LAT cycles after operands
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_quotient  out  DW  signed result
- out_div0  out  1  result came from denom==0
- out_ovf  out  1  result came from INT_MIN/-1

Behaviour:
- Reset (sync, active-high):
  - div_numer=0, div_denom=1; tag line cleared; FIFO emptied.
  - credits=FIFO_DEPTH; out_valid=0, out_quotient=0, out_div0=0, out_ovf=0.
  - Reset mid-operation discards all in-flight and buffered results; nothing emerges afterwards.
- in_ready = (credits≠0); combinational from registers only, never from in_valid.
- Issue happens when in_valid&&in_ready at cycle T:
  - div_numer/div_denom are loaded at T+1.
  - A tag {live=1, div0, ovf, sign} enters a DIV_LAT+1 stage shift register.
  - On cycles with no issue, a bubble tag (live=0) enters; operand registers hold their values.
- Special cases:
  - denom==0 sets div0. The divider gets denom=1 (numer unchanged).
  - Saturated result for div0: +(2^(DW-1)-1) if numer≥0, else -2^(DW-1).
  - numer==-2^(DW-1) && denom==-1 sets ovf; result +(2^(DW-1)-1). div0 has priority over ovf.
- Capture:
  - When the tag exits the line (cycle T+1+DIV_LAT) with live=1, the FIFO writes {quotient, div0, ovf}.
  - The quotient is the saturated value if either flag is set, otherwise div_quotient.
- Output:
  - FIFO head is registered onto the out_* signals (first-word-fall-through).
  - With FIFO empty, out_valid first rises at T+DIV_LAT+2.
  - out_quotient and flags hold stable while out_valid&&!out_ready.
- Credits:
  - Decrement on issue, increment on output handshake; both in the same cycle means no change.
  - Invariant: credits + in-flight + FIFO occupancy = FIFO_DEPTH, so the FIFO can never overflow.
- Throughput: one pair per cycle sustained while out_ready=1.
- Ordering: results are strictly in issue order.
- Pointers: FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: SDIV_STREAM_STATS_EN.
- When defined, adds outputs:
  - stat_div0_cnt[15:0] and stat_ovf_cnt[15:0], counting flagged results at the output handshake, saturating at 0xFFFF.
  - stat_busy_cnt[31:0], counting cycles with in_valid&&!in_ready, wrapping.
  - All three cleared by sys_rst.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sdiv_pkg holds:
  - constants DW_DEF, SDIV_MAX, SDIV_MIN;
  - the tag struct typedef {live, div0, ovf, sign};
  - a saturation-value function.
- One sub-module, sdiv_result_fifo: a synchronous FWFT FIFO parameterised by width and depth, with internal full/empty assertions.

Test Plan:
- Single issue 32765/-100 (behavioural divider model, truncating toward zero, DIV_LAT=4) → out_quotient=-327, div0=0, ovf=0; out_valid rises exactly at T+6.
- Back-to-back 10 pairs (i*1000)/7, out_ready=1 → 10 results in order, one per cycle; in_ready never drops.
- out_ready=0 while streaming → exactly FIFO_DEPTH pairs accepted, then in_ready=0. Releasing out_ready drains all 8 with no loss or duplication.
- 5/0 → 0x7FFFFFFF, div0=1; -5/0 → 0x80000000, div0=1; 0x80000000/-1 → 0x7FFFFFFF, ovf=1.
- Assert sys_rst for 1 cycle with 3 in flight and 2 buffered → out_valid=0 next cycle, no further results; credits restored (8 pairs accepted again).
- With SDIV_STREAM_STATS_EN: after the special-case test, stat_div0_cnt=2 and stat_ovf_cnt=1.

Source files
------------

// File: rtl/sdiv_pkg.sv
// Shared types and constants for the streaming signed-divider wrapper.
package sdiv_pkg;

    localparam int DW_DEF = 32;
    localparam logic [DW_DEF-1:0] SDIV_MAX = {1'b0, {(DW_DEF-1){1'b1}}};
    localparam logic [DW_DEF-1:0] SDIV_MIN = {1'b1, {(DW_DEF-1){1'b0}}};

    typedef struct packed {
        logic live;
        logic div0;
        logic ovf;
        logic sign;
    } sdiv_tag_t;

    // Only a zero divide of a negative numerator saturates toward the negative extreme.
    function automatic logic [DW_DEF-1:0] sdiv_sat_value(input sdiv_tag_t tag);
        return (tag.div0 && tag.sign) ? SDIV_MIN : SDIV_MAX;
    endfunction

endpackage

// File: rtl/sdiv_result_fifo.sv
// First-word-fall-through result FIFO: array storage plus a registered head,
// with a bypass so a write into an idle FIFO reaches the head one cycle later.
module sdiv_result_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_reg, rptr_reg;
    logic [AW:0]      count_reg;
    logic             head_valid_reg;
    logic [WIDTH-1:0] head_data_reg;

    logic mem_empty, mem_full, load_head, take_mem, bypass, mem_wr;

    assign mem_empty = (count_reg == '0);
    assign mem_full  = (count_reg == (AW+1)'(DEPTH));
    assign load_head = !head_valid_reg || rd_ready;
    assign take_mem  = load_head && !mem_empty;
    assign bypass    = load_head && mem_empty && wr_en;
    assign mem_wr    = wr_en && !bypass;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            head_valid_reg <= 1'b0;
            head_data_reg  <= '0;
        end else begin
            if (load_head) begin
                head_valid_reg <= take_mem || bypass;
            end
            if (take_mem) begin
                head_data_reg <= mem[rptr_reg];
                rptr_reg      <= rptr_reg + AW'(1);
            end else if (bypass) begin
                head_data_reg <= wr_data;
            end
            if (mem_wr) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(mem_wr) - (AW+1)'(take_mem);
        end
    end

    assign rd_valid = head_valid_reg;
    assign rd_data  = head_data_reg;

    a_no_overflow:  assert property (@(posedge clk) disable iff (srst) !(mem_wr && mem_full));
    a_no_underflow: assert property (@(posedge clk) disable iff (srst) !(take_mem && mem_empty));

endmodule

// File: rtl/sdiv_stream_ctrl.sv
// Valid/ready wrapper around a fixed-latency pipelined signed divider (DW up to DW_DEF).
// Define SDIV_STREAM_STATS_EN to add the stat_* result/busy counters.
module sdiv_stream_ctrl
    import sdiv_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int DIV_LAT    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_numer,
    input  logic [DW-1:0] in_denom,
    output logic [DW-1:0] div_numer,
    output logic [DW-1:0] div_denom,
    input  logic [DW-1:0] div_quotient,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_quotient,
    output logic          out_div0,
    output logic          out_ovf
`ifdef SDIV_STREAM_STATS_EN
   ,output logic [15:0]   stat_div0_cnt,
    output logic [15:0]   stat_ovf_cnt,
    output logic [31:0]   stat_busy_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [DW-1:0] q_min = {1'b1, {(DW-1){1'b0}}};

    logic [CW-1:0] credits_reg, credits_next;
    logic [DW-1:0] div_numer_reg, div_denom_reg;
    logic          issue, pop, in_div0, in_ovf;
    sdiv_tag_t     tag_new, tag_out;
    sdiv_tag_t     tag_reg  [DIV_LAT+1];
    sdiv_tag_t     tag_next [DIV_LAT+1];
    logic [DW_DEF-1:0] sat_full;
    logic [DW-1:0]     cap_quotient;
    logic [DW+1:0]     head_data;

    // Credits count free result slots not yet claimed by an in-flight operation.
    assign in_ready = (credits_reg != '0);
    assign issue    = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign in_div0  = (in_denom == '0);
    assign in_ovf   = !in_div0 && (in_numer == q_min) && (in_denom == '1);

    always_comb begin
        tag_new = '0;
        if (issue) begin
            tag_new.live = 1'b1;
            tag_new.div0 = in_div0;
            tag_new.ovf  = in_ovf;
            tag_new.sign = in_numer[DW-1];
        end
    end

    for (genvar gi = 0; gi <= DIV_LAT; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            assign tag_next[gi] = tag_new;
        end else begin : g_shift
            assign tag_next[gi] = tag_reg[gi-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_numer_reg <= '0;
            div_denom_reg <= DW'(1);
            for (int i = 0; i <= DIV_LAT; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg <= tag_next;
            if (issue) begin
                div_numer_reg <= in_numer;
                div_denom_reg <= in_div0 ? DW'(1) : in_denom;
            end
        end
    end

    always_comb begin
        credits_next = credits_reg;
        case ({issue, pop})
            2'b10:   credits_next = credits_reg - CW'(1);
            2'b01:   credits_next = credits_reg + CW'(1);
            default: credits_next = credits_reg;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            credits_reg <= CW'(FIFO_DEPTH);
        end else begin
            credits_reg <= credits_next;
        end
    end

    assign div_numer = div_numer_reg;
    assign div_denom = div_denom_reg;

    // The divider's own answer is meaningless for flagged operations; substitute the saturated value.
    assign tag_out      = tag_reg[DIV_LAT];
    assign sat_full     = sdiv_sat_value(tag_out);
    assign cap_quotient = (tag_out.div0 || tag_out.ovf) ? DW'(sat_full >> (DW_DEF - DW)) : div_quotient;

    sdiv_result_fifo #(
        .WIDTH (DW + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (sys_clk),
        .srst     (sys_rst),
        .wr_en    (tag_out.live),
        .wr_data  ({cap_quotient, tag_out.div0, tag_out.ovf}),
        .rd_valid (out_valid),
        .rd_data  (head_data),
        .rd_ready (out_ready)
    );

    assign out_quotient = head_data[DW+1:2];
    assign out_div0     = head_data[1];
    assign out_ovf      = head_data[0];

    a_credit_bound: assert property (@(posedge sys_clk) disable iff (sys_rst) credits_reg <= CW'(FIFO_DEPTH));

`ifdef SDIV_STREAM_STATS_EN
    logic [15:0] stat_div0_reg, stat_ovf_reg;
    logic [31:0] stat_busy_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stat_div0_reg <= '0;
            stat_ovf_reg  <= '0;
            stat_busy_reg <= '0;
        end else begin
            if (pop && out_div0 && stat_div0_reg != 16'hFFFF) begin
                stat_div0_reg <= stat_div0_reg + 16'd1;
            end
            if (pop && out_ovf && stat_ovf_reg != 16'hFFFF) begin
                stat_ovf_reg <= stat_ovf_reg + 16'd1;
            end
            if (in_valid && !in_ready) begin
                stat_busy_reg <= stat_busy_reg + 32'd1;
            end
        end
    end

    assign stat_div0_cnt = stat_div0_reg;
    assign stat_ovf_cnt  = stat_ovf_reg;
    assign stat_busy_cnt = stat_busy_reg;
`endif

endmodule

// File: tb/tb_sdiv_stream_ctrl.sv
// Bench for sdiv_stream_ctrl: behavioural divider, queue-based result model,
// per-cycle compare process and directed vectors with literal expectations.
module tb_sdiv_stream_ctrl;

    logic        sys_clk, sys_rst;
    logic        in_valid, in_ready;
    logic [31:0] in_numer, in_denom;
    logic [31:0] div_numer, div_denom, div_quotient;
    logic        out_valid, out_ready;
    logic [31:0] out_quotient;
    logic        out_div0, out_ovf;
`ifdef SDIV_STREAM_STATS_EN
    logic [15:0] stat_div0_cnt, stat_ovf_cnt;
    logic [31:0] stat_busy_cnt;
`endif

    sdiv_stream_ctrl #(.DW(32), .DIV_LAT(4), .FIFO_DEPTH(8)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_numer     (in_numer),
        .in_denom     (in_denom),
        .div_numer    (div_numer),
        .div_denom    (div_denom),
        .div_quotient (div_quotient),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_div0     (out_div0),
        .out_ovf      (out_ovf)
`ifdef SDIV_STREAM_STATS_EN
       ,.stat_div0_cnt (stat_div0_cnt),
        .stat_ovf_cnt  (stat_ovf_cnt),
        .stat_busy_cnt (stat_busy_cnt)
`endif
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Divider stand-in: truncating division, four cycles from operands to quotient.
    logic [31:0] dpipe [4];
    always @(posedge sys_clk) begin
        for (int i = 3; i > 0; i--) dpipe[i] <= dpipe[i-1];
        dpipe[0] <= (div_denom == 32'd0) ? 32'd0
                  : 32'(longint'($signed(div_numer)) / longint'($signed(div_denom)));
    end
    assign div_quotient = dpipe[3];

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] q;
        logic        z;
        logic        o;
    } exp_t;

    function automatic exp_t model(input logic [31:0] n, input logic [31:0] d);
        exp_t e;
        e.z = (d == 32'd0);
        e.o = !e.z && (n == 32'h8000_0000) && (d == 32'hFFFF_FFFF);
        if (e.z)      e.q = n[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else if (e.o) e.q = 32'h7FFF_FFFF;
        else          e.q = 32'(longint'($signed(n)) / longint'($signed(d)));
        return e;
    endfunction

    exp_t        exp_q [$];
    int          outstanding = 0;
    logic [31:0] rx_q [$];
    logic        rx_z [$];
    logic        rx_o [$];
    int          rx_cyc [$];
    int          iss_cyc [$];

    // Compare process: inputs change just after posedge, so negedge values are what the next edge sees.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            exp_q.delete();
            outstanding = 0;
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, outstanding < 8});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected no output (cycle %0d)", out_quotient, cyc);
                end else begin
                    check("out_quotient", out_quotient, exp_q[0].q);
                    check("out_div0", {31'd0, out_div0}, {31'd0, exp_q[0].z});
                    check("out_ovf", {31'd0, out_ovf}, {31'd0, exp_q[0].o});
                end
                if (out_ready) begin
                    rx_q.push_back(out_quotient);
                    rx_z.push_back(out_div0);
                    rx_o.push_back(out_ovf);
                    rx_cyc.push_back(cyc);
                    if (exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        outstanding--;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_numer, in_denom));
                outstanding++;
                iss_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rx_z.delete();
        rx_o.delete();
        rx_cyc.delete();
        iss_cyc.delete();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    task automatic fill_and_drain(input int base);
        int k;
        k = 0;
        out_ready = 1'b0;
        tick();
        repeat (12) begin
            in_valid = 1'b1;
            in_numer = 32'(3 * (k + base) + 1);
            in_denom = 32'd3;
            @(negedge sys_clk);
            if (in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        check("fill_accepted", k, 8);
        check("fill_issue_log", iss_cyc.size(), 8);
        @(negedge sys_clk);
        check("fill_in_ready", {31'd0, in_ready}, 32'd0);
        check("fill_head", out_quotient, base);
        repeat (5) tick();
        check("fill_no_pop", rx_q.size(), 0);
        out_ready = 1'b1;
        wait_rx(8, 40);
        repeat (10) tick();
        check("drain_count", rx_q.size(), 8);
        for (int i = 0; i < rx_q.size(); i++) check("drain_q", rx_q[i], 32'(base + i));
    endtask

    logic [31:0] t2_exp [10] = '{32'd0, 32'd142, 32'd285, 32'd428, 32'd571,
                                 32'd714, 32'd857, 32'd1000, 32'd1142, 32'd1285};
    logic [31:0] t4_n [5] = '{32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] t4_d [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd2};
    logic [31:0] t4_q [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD};
    logic        t4_z [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        t4_o [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int drops;
        sys_rst   = 1'b1;
        in_valid  = 1'b0;
        in_numer  = '0;
        in_denom  = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge sys_clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_quotient", out_quotient, 32'd0);
        check("rst_out_flags", {30'd0, out_div0, out_ovf}, 32'd0);
        check("rst_div_numer", div_numer, 32'd0);
        check("rst_div_denom", div_denom, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        sys_rst = 1'b0;

        // Single issue and latency
        clear_logs();
        tick();
        in_valid = 1'b1;
        in_numer = 32'd32765;
        in_denom = 32'hFFFF_FF9C;
        tick();
        in_valid = 1'b0;
        @(negedge sys_clk);
        check("t1_div_numer", div_numer, 32'd32765);
        check("t1_div_denom", div_denom, 32'hFFFF_FF9C);
        wait_rx(1, 20);
        if (rx_q.size() >= 1 && iss_cyc.size() >= 1) begin
            check("t1_quotient", rx_q[0], 32'hFFFF_FEB9);
            check("t1_flags", {30'd0, rx_z[0], rx_o[0]}, 32'd0);
            check("t1_latency", rx_cyc[0] - iss_cyc[0], 32'd6);
        end

        // Back-to-back stream
        clear_logs();
        drops = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_numer = 32'(i * 1000);
            in_denom = 32'd7;
            @(negedge sys_clk);
            if (!in_ready) drops++;
            tick();
        end
        in_valid = 1'b0;
        check("t2_ready_drops", drops, 0);
        wait_rx(10, 30);
        for (int i = 0; i < rx_q.size() && i < 10; i++) begin
            check("t2_quotient", rx_q[i], t2_exp[i]);
            check("t2_spacing", rx_cyc[i] - rx_cyc[0], i);
        end

        // Backpressure: fill exactly FIFO_DEPTH, then drain
        clear_logs();
        fill_and_drain(1);

        // Special cases
        clear_logs();
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_numer = t4_n[i];
            in_denom = t4_d[i];
            @(negedge sys_clk);
            if (i == 1) begin
                check("t4_div_numer", div_numer, 32'd5);
                check("t4_div_denom", div_denom, 32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        wait_rx(5, 30);
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            check("t4_quotient", rx_q[i], t4_q[i]);
            check("t4_div0", {31'd0, rx_z[i]}, {31'd0, t4_z[i]});
            check("t4_ovf", {31'd0, rx_o[i]}, {31'd0, t4_o[i]});
        end
`ifdef SDIV_STREAM_STATS_EN
        @(negedge sys_clk);
        check("stat_div0", {16'd0, stat_div0_cnt}, 32'd2);
        check("stat_ovf", {16'd0, stat_ovf_cnt}, 32'd1);
        check("stat_busy", stat_busy_cnt, 32'd4);
`endif

        // Reset with 2 buffered and 3 in flight
        clear_logs();
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_numer = 32'(50 + i);
            in_denom = 32'd1;
            tick();
            in_valid = 1'b0;
            if (i == 1) repeat (8) tick();
        end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("t5_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        check("t5_out_quotient", out_quotient, 32'd0);
`ifdef SDIV_STREAM_STATS_EN
        check("t5_stat_div0", {16'd0, stat_div0_cnt}, 32'd0);
`endif
        out_ready = 1'b1;
        repeat (15) tick();
        check("t5_no_results", rx_q.size(), 0);
        clear_logs();
        fill_and_drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
